// File: rtl/dec_onehot_scoreboard.sv
// Registered one-hot destination decoder with a per-entry busy scoreboard.
// Set marks an entry busy and pulses dec_out. Clear retires the entry. Two read ports expose busy bits to hazard logic.
module dec_onehot_scoreboard #(
    parameter int SEL_W     = 5,
    parameter int ZERO_HOLD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    set_valid,
    input  logic [SEL_W-1:0]        set_sel,
    input  logic                    clr_valid,
    input  logic [SEL_W-1:0]        clr_sel,
    input  logic [SEL_W-1:0]        chk_sel_a,
    input  logic [SEL_W-1:0]        chk_sel_b,
    output logic [(1<<SEL_W)-1:0]   dec_out,
    output logic [(1<<SEL_W)-1:0]   busy,
    output logic                    busy_a,
    output logic                    busy_b,
    output logic [SEL_W:0]          busy_cnt,
    output logic                    full,
    output logic                    err
);

    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = SEL_W + 1;

    logic [N-1:0]     set_m;
    logic [N-1:0]     clr_m;
    logic [N-1:0]     dec_q, dec_d;
    logic [N-1:0]     busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic set_new;
    logic set_dup;
    logic clr_retire;
    logic clr_bad;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (set_valid) set_m[set_sel] = 1'b1;
        if (clr_valid) clr_m[clr_sel] = 1'b1;
        // Index 0 is hard-wired zero. Requests to it must not change busy, the count or err.
        if (ZERO_HOLD != 0) begin
            set_m[0] = 1'b0;
            clr_m[0] = 1'b0;
        end
    end

    // Classify this cycle's requests against the registered busy vector.
    always_comb begin
        set_new    = |(set_m & ~busy_q);
        set_dup    = |(set_m &  busy_q);
        clr_retire = |(clr_m &  busy_q & ~set_m);
        clr_bad    = |(clr_m & ~busy_q & ~set_m);
    end

    always_comb begin
        dec_d  = dec_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (enable) begin
            dec_d  = set_m;
            busy_d = (busy_q & ~clr_m) | set_m;
            // At most one set and one clear per cycle, so the count moves by at most one.
            if (set_new && !clr_retire) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (clr_retire && !set_new) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (set_dup || clr_bad) err_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            dec_q  <= dec_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign dec_out  = dec_q;
    assign busy     = busy_q;
    assign busy_a   = busy_q[chk_sel_a];
    assign busy_b   = busy_q[chk_sel_b];
    assign busy_cnt = cnt_q;
    assign full     = (cnt_q == CNT_W'(N - ZERO_HOLD));
    assign err      = err_q;

endmodule

// File: tb/tb_dec_onehot_scoreboard.sv
// Directed bench for dec_onehot_scoreboard.
// A per-entry array model is compared on every falling edge, and literal expectations pin the key scenarios.
module tb_dec_onehot_scoreboard;

    localparam int SEL_W     = 5;
    localparam int ZERO_HOLD = 1;
    localparam int N         = 1 << SEL_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             set_valid;
    logic [SEL_W-1:0] set_sel;
    logic             clr_valid;
    logic [SEL_W-1:0] clr_sel;
    logic [SEL_W-1:0] chk_sel_a;
    logic [SEL_W-1:0] chk_sel_b;
    logic [N-1:0]     dec_out;
    logic [N-1:0]     busy;
    logic             busy_a;
    logic             busy_b;
    logic [SEL_W:0]   busy_cnt;
    logic             full;
    logic             err;

    int n_vec = 0;
    int n_err = 0;

    dec_onehot_scoreboard #(.SEL_W(SEL_W), .ZERO_HOLD(ZERO_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .set_valid (set_valid),
        .set_sel   (set_sel),
        .clr_valid (clr_valid),
        .clr_sel   (clr_sel),
        .chk_sel_a (chk_sel_a),
        .chk_sel_b (chk_sel_b),
        .dec_out   (dec_out),
        .busy      (busy),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_cnt  (busy_cnt),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: one flag per entry, last accepted set index, and a sticky error flag.
    bit m_busy [N];
    int m_dec;
    bit m_err;

    function automatic int eff_idx(input logic v, input logic [SEL_W-1:0] sel);
        if (!v || (ZERO_HOLD != 0 && sel == 0)) return -1;
        return int'(sel);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_busy[i] <= 1'b0;
            m_dec <= -1;
            m_err <= 1'b0;
        end else if (enable) begin
            m_dec <= eff_idx(set_valid, set_sel);
            if (eff_idx(set_valid, set_sel) >= 0 && m_busy[eff_idx(set_valid, set_sel)])
                m_err <= 1'b1;
            if (eff_idx(clr_valid, clr_sel) >= 0 && !m_busy[eff_idx(clr_valid, clr_sel)]
                && eff_idx(clr_valid, clr_sel) != eff_idx(set_valid, set_sel))
                m_err <= 1'b1;
            // The later write wins, so a set beats a clear of the same entry.
            if (eff_idx(clr_valid, clr_sel) >= 0) m_busy[eff_idx(clr_valid, clr_sel)] <= 1'b0;
            if (eff_idx(set_valid, set_sel) >= 0) m_busy[eff_idx(set_valid, set_sel)] <= 1'b1;
        end
    end

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_dec();
        logic [N-1:0] v = '0;
        if (m_dec >= 0) v[m_dec] = 1'b1;
        return v;
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    always @(negedge clk) begin
        check("m_dec_out",  64'(dec_out),  64'(exp_dec()));
        check("m_busy",     64'(busy),     64'(exp_busy()));
        check("m_busy_a",   64'(busy_a),   64'(m_busy[chk_sel_a]));
        check("m_busy_b",   64'(busy_b),   64'(m_busy[chk_sel_b]));
        check("m_busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
        check("m_full",     64'(full),     64'(exp_cnt() == N - ZERO_HOLD));
        check("m_err",      64'(err),      64'(m_err));
    end

    // Advance one rising edge, then settle just after the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        set_valid = 1'b0;
        clr_valid = 1'b0;
    endtask

    task automatic do_set(input int s);
        set_valid = 1'b1;
        set_sel   = SEL_W'(s);
    endtask

    task automatic do_clr(input int c);
        clr_valid = 1'b1;
        clr_sel   = SEL_W'(c);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        set_valid = 1'b0;
        set_sel   = '0;
        clr_valid = 1'b0;
        clr_sel   = '0;
        chk_sel_a = SEL_W'(7);
        chk_sel_b = SEL_W'(5);
        repeat (2) step();
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_cnt",  64'(busy_cnt), 64'h0);
        rst_n = 1'b1;

        // A single set pulses dec_out for one cycle and marks the entry busy.
        do_set(7);
        step();
        check("set7_dec",  64'(dec_out),  64'h80);
        check("set7_busy", 64'(busy),     64'h80);
        check("set7_cnt",  64'(busy_cnt), 64'd1);
        check("set7_qa",   64'(busy_a),   64'd1);
        idle();
        step();
        check("set7_dec_gone", 64'(dec_out), 64'h0);

        // Build busy = 0xF0, then apply an asynchronous reset in mid-cycle.
        for (int s = 4; s <= 6; s++) begin
            do_set(s);
            step();
        end
        idle();
        step();
        check("f0_busy", 64'(busy),     64'hF0);
        check("f0_cnt",  64'(busy_cnt), 64'd4);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy),     64'h0);
        check("arst_cnt",  64'(busy_cnt), 64'h0);
        check("arst_dec",  64'(dec_out),  64'h0);
        check("arst_err",  64'(err),      64'h0);
        step();
        rst_n = 1'b1;

        // Set and clear of an already busy entry in the same cycle: the set wins and the duplicate set is flagged.
        do_set(5);
        step();
        do_set(5);
        do_clr(5);
        step();
        check("dup_busy", 64'(busy),     64'h20);
        check("dup_cnt",  64'(busy_cnt), 64'd1);
        check("dup_err",  64'(err),      64'd1);
        pulse_reset();

        // Index 0 is ignored for both set and clear.
        do_set(0);
        step();
        check("z_dec",  64'(dec_out),  64'h0);
        check("z_busy", 64'(busy),     64'h0);
        check("z_cnt",  64'(busy_cnt), 64'd0);
        check("z_err",  64'(err),      64'd0);
        idle();
        do_clr(0);
        step();
        check("zclr_err", 64'(err), 64'd0);
        idle();

        // Clear one entry while setting a different one.
        do_set(9);
        step();
        do_set(10);
        do_clr(9);
        chk_sel_a = SEL_W'(10);
        chk_sel_b = SEL_W'(9);
        step();
        check("swap_busy", 64'(busy),     64'h400);
        check("swap_cnt",  64'(busy_cnt), 64'd1);
        check("swap_qa",   64'(busy_a),   64'd1);
        check("swap_qb",   64'(busy_b),   64'd0);
        check("swap_err",  64'(err),      64'd0);
        pulse_reset();

        // Fill every trackable entry, then clear the top entry twice.
        for (int s = 1; s < N; s++) begin
            do_set(s);
            chk_sel_a = SEL_W'(s);
            step();
        end
        idle();
        check("fill_cnt",  64'(busy_cnt), 64'd31);
        check("fill_full", 64'(full),     64'd1);
        check("fill_err",  64'(err),      64'd0);
        do_clr(31);
        step();
        check("clr31_cnt",  64'(busy_cnt), 64'd30);
        check("clr31_full", 64'(full),     64'd0);
        check("clr31_err",  64'(err),      64'd0);
        step();
        check("clr31_again_err", 64'(err),      64'd1);
        check("clr31_again_cnt", 64'(busy_cnt), 64'd30);
        pulse_reset();

        // With enable low, every register holds and the query port still reads the held state.
        do_set(4);
        step();
        idle();
        enable = 1'b0;
        do_set(3);
        do_clr(4);
        chk_sel_a = SEL_W'(0);
        chk_sel_b = SEL_W'(3);
        step();
        check("hold_busy", 64'(busy),     64'h10);
        check("hold_dec",  64'(dec_out),  64'h10);
        check("hold_cnt",  64'(busy_cnt), 64'd1);
        check("hold_err",  64'(err),      64'd0);
        chk_sel_a = SEL_W'(4);
        #1;
        check("hold_qa", 64'(busy_a), 64'd1);
        check("hold_qb", 64'(busy_b), 64'd0);
        step();
        enable = 1'b1;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
